// File: rtl/pipeline_arith_issue_unit.sv
// Issue stage for the arithmetic pipeline: buffers upstream ops in a FIFO and issues them in order.
// A per-register countdown scoreboard holds back RAW-dependent ops for HAZ_WAIT cycles.
module pipeline_arith_issue_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned HAZ_WAIT = 0,
    parameter int unsigned DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic          in_reg_write,
    output logic          issue_valid,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [4:0]    rs,
    output logic [4:0]    rt,
    output logic [4:0]    rd,
    output logic          reg_write,
    output logic [15:0]   stall_cycles
);

    localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [2:0]  WAIT     = 3'(HAZ_WAIT);

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic          rw;
    } op_t;

    op_t           mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [2:0]    cnt_q [32];
    logic [2:0]    cnt_d [32];
    logic [15:0]   stall_q, stall_d;

    logic          valid_q, valid_d;
    op_t           out_q, out_d;

    op_t           head;
    op_t           in_op;
    logic          empty, full, hazard, issue, push;

    assign in_op = '{a: in_a, b: in_b, rs: in_rs, rt: in_rt, rd: in_rd, rw: in_reg_write};
    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Register 0 is hard-wired, so it never creates a dependency.
    assign hazard = !empty &&
                    (((head.rs != 5'd0) && (cnt_q[head.rs] != 3'd0)) ||
                     ((head.rt != 5'd0) && (cnt_q[head.rt] != 3'd0)));
    assign issue  = !empty && !hazard;
    assign push   = in_valid && !full;

    assign in_ready = !full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        valid_d  = 1'b0;
        out_d    = out_q;
        out_d.rw = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            valid_d  = 1'b1;
            out_d    = head;
        end
        if (push && !issue) begin
            count_d = count_q + 1'b1;
        end else if (issue && !push) begin
            count_d = count_q - 1'b1;
        end
        if (hazard && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
        end
        // A fresh write restarts the wait even if an older countdown is still running.
        if (issue && head.rw && (head.rd != 5'd0)) begin
            cnt_d[head.rd] = WAIT;
        end
        cnt_d[0] = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            valid_q  <= 1'b0;
            out_q    <= '0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 3'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q] <= in_op;
        end
    end

    assign issue_valid  = valid_q;
    assign a            = out_q.a;
    assign b            = out_q.b;
    assign rs           = out_q.rs;
    assign rt           = out_q.rt;
    assign rd           = out_q.rd;
    assign reg_write    = out_q.rw;
    assign stall_cycles = stall_q;

endmodule
